// File: rtl/dac_tx_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : dac_tx_scheduler_if
//  Description : One AXI4-Stream link (TDATA/TVALID/TLAST/TREADY). The master
//                modport drives the data side, the slave modport drives TREADY.
//  Ports       : TDATA  - C_AXIS_TDATA_WIDTH data word
//                TVALID - data valid
//                TLAST  - last beat of packet
//                TREADY - sink ready
//  Revision    : 1.0 - initial release
// ============================================================================
interface dac_tx_scheduler_if #(
  parameter int C_AXIS_TDATA_WIDTH = 32
) ();
  logic [C_AXIS_TDATA_WIDTH-1:0] TDATA;
  logic                          TVALID;
  logic                          TLAST;
  logic                          TREADY;

  modport master (output TDATA, output TVALID, output TLAST, input  TREADY);
  modport slave  (input  TDATA, input  TVALID, input  TLAST, output TREADY);
endinterface
`default_nettype wire

// File: rtl/dac_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : dac_tx_scheduler
//  Description : Builds DAC frames of the form
//                  preamble (S1) -> guard zeros -> payload (S0) -> IFG zeros
//                and repeats for frame_count frames (0 = until stopped).
//                Gaps are filled with ZERO_WORD (mid-scale, 0 V at the DAC).
//  Ports       : ACLK, ARESET       - clock, asynchronous active-high reset
//                start, stop        - control pulses
//                guard_len, ifg_len - gap lengths in beats (latched on start)
//                frame_count        - frames to send, 0 = continuous
//                busy, dac_stream_enable, frames_sent, underrun_cnt, state
//                S0_AXIS (slave)    - payload source
//                S1_AXIS (slave)    - preamble source
//                M_AXIS  (master)   - stream toward the DAC
//  Revision    : 1.0 - initial release
// ============================================================================
module dac_tx_scheduler #(
  parameter int                            C_AXIS_TDATA_WIDTH = 32,
  parameter logic [C_AXIS_TDATA_WIDTH-1:0] ZERO_WORD          = {2'b00, 14'h1FFF, 2'b00, 14'h1FFF}
) (
  input  wire logic         ACLK,
  input  wire logic         ARESET,
  input  wire logic         start,
  input  wire logic         stop,
  input  wire logic [15:0]  guard_len,
  input  wire logic [15:0]  ifg_len,
  input  wire logic [15:0]  frame_count,
  output logic              busy,
  output logic              dac_stream_enable,
  output logic [15:0]       frames_sent,
  output logic [15:0]       underrun_cnt,
  output logic [2:0]        state,
  dac_tx_scheduler_if.slave  S0_AXIS,
  dac_tx_scheduler_if.slave  S1_AXIS,
  dac_tx_scheduler_if.master M_AXIS
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PREAMBLE = 3'd1,
    S_GUARD    = 3'd2,
    S_PAYLOAD  = 3'd3,
    S_IFG      = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_guard_len;
  logic [15:0] r_ifg_len;
  logic [15:0] r_frame_count;
  logic [15:0] r_cnt;
  logic [15:0] r_frames_sent;
  logic [15:0] r_underrun_cnt;
  logic        r_stop_pending;

  logic        w_s1_hs;
  logic        w_s0_hs;
  logic        w_zero_hs;
  logic        w_zero_last;
  logic        w_frame_end;
  logic        w_last_frame;
  logic        w_underrun;

  assign w_s1_hs     = (r_state == S_PREAMBLE) && S1_AXIS.TVALID && M_AXIS.TREADY;
  assign w_s0_hs     = (r_state == S_PAYLOAD)  && S0_AXIS.TVALID && M_AXIS.TREADY;
  assign w_zero_hs   = ((r_state == S_GUARD) || (r_state == S_IFG)) && M_AXIS.TREADY;
  assign w_zero_last = w_zero_hs && (r_cnt == 16'd1);
  assign w_frame_end = w_s0_hs && S0_AXIS.TLAST;
  assign w_last_frame = (r_frame_count != 16'd0) &&
                        ((r_frames_sent + 16'd1) == r_frame_count);
  assign w_underrun  = M_AXIS.TREADY &&
                       (((r_state == S_PREAMBLE) && !S1_AXIS.TVALID) ||
                        ((r_state == S_PAYLOAD)  && !S0_AXIS.TVALID));

  assign busy              = (r_state != S_IDLE);
  assign dac_stream_enable = busy;
  assign frames_sent       = r_frames_sent;
  assign underrun_cnt      = r_underrun_cnt;
  assign state             = r_state;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next state plus the stream muxes; only the muxes are combinational paths.
  always_comb begin
    w_state_next    = r_state;
    M_AXIS.TDATA    = ZERO_WORD;
    M_AXIS.TVALID   = 1'b0;
    M_AXIS.TLAST    = 1'b0;
    S0_AXIS.TREADY  = 1'b0;
    S1_AXIS.TREADY  = 1'b0;
    case (r_state)
      S_IDLE: begin
        // stop in the same cycle as start wins
        if (start && !stop) w_state_next = S_PREAMBLE;
      end
      S_PREAMBLE: begin
        M_AXIS.TDATA   = S1_AXIS.TDATA;
        M_AXIS.TVALID  = S1_AXIS.TVALID;
        S1_AXIS.TREADY = M_AXIS.TREADY;
        if (w_s1_hs && S1_AXIS.TLAST)
          w_state_next = (r_guard_len == 16'd0) ? S_PAYLOAD : S_GUARD;
      end
      S_GUARD: begin
        M_AXIS.TVALID = 1'b1;
        if (stop)             w_state_next = S_IDLE;
        else if (w_zero_last) w_state_next = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        M_AXIS.TDATA   = S0_AXIS.TDATA;
        M_AXIS.TVALID  = S0_AXIS.TVALID;
        M_AXIS.TLAST   = S0_AXIS.TLAST;
        S0_AXIS.TREADY = M_AXIS.TREADY;
        if (w_frame_end) begin
          if (r_stop_pending || w_last_frame) w_state_next = S_IDLE;
          else if (r_ifg_len == 16'd0)        w_state_next = S_PREAMBLE;
          else                                w_state_next = S_IFG;
        end
      end
      S_IFG: begin
        M_AXIS.TVALID = 1'b1;
        if (stop)             w_state_next = S_IDLE;
        else if (w_zero_last) w_state_next = S_PREAMBLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_guard_len    <= 16'd0;
      r_ifg_len      <= 16'd0;
      r_frame_count  <= 16'd0;
      r_cnt          <= 16'd0;
      r_frames_sent  <= 16'd0;
      r_underrun_cnt <= 16'd0;
      r_stop_pending <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && (w_state_next == S_PREAMBLE)) begin
        r_guard_len   <= guard_len;
        r_ifg_len     <= ifg_len;
        r_frame_count <= frame_count;
        r_frames_sent <= 16'd0;
      end else if (w_frame_end && (r_frames_sent != 16'hFFFF)) begin
        r_frames_sent <= r_frames_sent + 16'd1;
      end

      // Beat counter is loaded on the transition into a gap state and
      // counts down on every accepted zero beat.
      if ((r_state == S_PREAMBLE) && (w_state_next == S_GUARD))
        r_cnt <= r_guard_len;
      else if ((r_state == S_PAYLOAD) && (w_state_next == S_IFG))
        r_cnt <= r_ifg_len;
      else if (w_zero_hs)
        r_cnt <= r_cnt - 16'd1;

      if (w_underrun && (r_underrun_cnt != 16'hFFFF))
        r_underrun_cnt <= r_underrun_cnt + 16'd1;

      if (busy && (w_state_next == S_IDLE)) r_stop_pending <= 1'b0;
      else if (busy && stop)                r_stop_pending <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dac_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dac_tx_scheduler
//  Description : Directed self-checking bench for dac_tx_scheduler.
//                Preamble source: 8-beat packets, data A000_0000+n.
//                Payload source : 16-beat packets, data 5000_0000+n.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dac_tx_scheduler;

  localparam logic [31:0] ZW = 32'h1FFF_1FFF;
  localparam int PRE_LEN = 8;
  localparam int PAY_LEN = 16;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        start;
  logic        stop;
  logic [15:0] guard_len;
  logic [15:0] ifg_len;
  logic [15:0] frame_count;
  logic        busy;
  logic        dac_stream_enable;
  logic [15:0] frames_sent;
  logic [15:0] underrun_cnt;
  logic [2:0]  state;

  dac_tx_scheduler_if #(.C_AXIS_TDATA_WIDTH(32)) s0_if ();
  dac_tx_scheduler_if #(.C_AXIS_TDATA_WIDTH(32)) s1_if ();
  dac_tx_scheduler_if #(.C_AXIS_TDATA_WIDTH(32)) m_if ();

  dac_tx_scheduler dut (
    .ACLK              (ACLK),
    .ARESET            (ARESET),
    .start             (start),
    .stop              (stop),
    .guard_len         (guard_len),
    .ifg_len           (ifg_len),
    .frame_count       (frame_count),
    .busy              (busy),
    .dac_stream_enable (dac_stream_enable),
    .frames_sent       (frames_sent),
    .underrun_cnt      (underrun_cnt),
    .state             (state),
    .S0_AXIS           (s0_if.slave),
    .S1_AXIS           (s1_if.slave),
    .M_AXIS            (m_if.master)
  );

  always #5 ACLK = ~ACLK;

  // ---------------- source models ----------------
  logic [15:0] s1_idx, s1_seq, s0_idx, s0_seq;
  logic        s0_stall;
  logic        toggle_rdy;
  logic        m_tready;

  assign s1_if.TVALID = 1'b1;
  assign s1_if.TDATA  = 32'hA000_0000 + {16'h0, s1_seq};
  assign s1_if.TLAST  = (s1_idx == 16'(PRE_LEN - 1));
  assign s0_if.TVALID = !s0_stall;
  assign s0_if.TDATA  = 32'h5000_0000 + {16'h0, s0_seq};
  assign s0_if.TLAST  = (s0_idx == 16'(PAY_LEN - 1));
  assign m_if.TREADY  = m_tready;

  always @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      s1_idx <= 16'd0; s1_seq <= 16'd0; s0_idx <= 16'd0; s0_seq <= 16'd0;
      m_tready <= 1'b1;
    end else begin
      if (s1_if.TVALID && s1_if.TREADY) begin
        s1_seq <= s1_seq + 16'd1;
        s1_idx <= s1_if.TLAST ? 16'd0 : s1_idx + 16'd1;
      end
      if (s0_if.TVALID && s0_if.TREADY) begin
        s0_seq <= s0_seq + 16'd1;
        s0_idx <= s0_if.TLAST ? 16'd0 : s0_idx + 16'd1;
      end
      m_tready <= toggle_rdy ? ~m_tready : 1'b1;
    end
  end

  // ---------------- sink capture (mid-cycle) ----------------
  logic [31:0] cap_d[$];
  logic        cap_l[$];
  logic [31:0] exp_d[$];
  logic        exp_l[$];

  always @(negedge ACLK) begin
    if (ARESET) begin
      cap_d.delete();
      cap_l.delete();
    end else if (m_if.TVALID && m_if.TREADY) begin
      cap_d.push_back(m_if.TDATA);
      cap_l.push_back(m_if.TLAST);
    end
  end

  // ---------------- checking helpers ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic do_reset();
    tick();
    ARESET = 1'b1; start = 1'b0; stop = 1'b0; s0_stall = 1'b0; toggle_rdy = 1'b0;
    repeat (2) tick();
    ARESET = 1'b0;
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_state(input string tag, input logic [2:0] target, input int budget);
    int n;
    n = 0;
    while (state !== target && n < budget) begin
      tick();
      n++;
    end
    check(tag, 64'(state), 64'(target));
  endtask

  task automatic build_expect(input int guard, input int ifg, input int frames);
    logic [31:0] n1, n0;
    n1 = 32'd0; n0 = 32'd0;
    exp_d.delete(); exp_l.delete();
    for (int f = 0; f < frames; f++) begin
      for (int i = 0; i < PRE_LEN; i++) begin
        exp_d.push_back(32'hA000_0000 + n1); exp_l.push_back(1'b0); n1++;
      end
      for (int i = 0; i < guard; i++) begin
        exp_d.push_back(ZW); exp_l.push_back(1'b0);
      end
      for (int i = 0; i < PAY_LEN; i++) begin
        exp_d.push_back(32'h5000_0000 + n0); exp_l.push_back(i == PAY_LEN - 1); n0++;
      end
      if (f < frames - 1)
        for (int i = 0; i < ifg; i++) begin
          exp_d.push_back(ZW); exp_l.push_back(1'b0);
        end
    end
  endtask

  task automatic compare_stream(input string tag);
    int n;
    check({tag, "_len"}, 64'(cap_d.size()), 64'(exp_d.size()));
    n = (cap_d.size() < exp_d.size()) ? cap_d.size() : exp_d.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_data[%0d]", tag, i), 64'(cap_d[i]), 64'(exp_d[i]));
      check($sformatf("%s_last[%0d]", tag, i), 64'(cap_l[i]), 64'(exp_l[i]));
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    ARESET = 1'b1; start = 1'b0; stop = 1'b0; s0_stall = 1'b0; toggle_rdy = 1'b0;
    guard_len = 16'd3; ifg_len = 16'd4; frame_count = 16'd2;
    repeat (2) @(posedge ACLK);
    #1;
    check("rst_state",   64'(state), 64'd0);
    check("rst_busy",    64'(busy), 64'd0);
    check("rst_enable",  64'(dac_stream_enable), 64'd0);
    check("rst_tvalid",  64'(m_if.TVALID), 64'd0);
    check("rst_tlast",   64'(m_if.TLAST), 64'd0);
    check("rst_tdata",   64'(m_if.TDATA), 64'(ZW));
    check("rst_s0ready", 64'(s0_if.TREADY), 64'd0);
    check("rst_s1ready", 64'(s1_if.TREADY), 64'd0);
    check("rst_frames",  64'(frames_sent), 64'd0);
    check("rst_underrun",64'(underrun_cnt), 64'd0);
    ARESET = 1'b0;
    tick();

    // 1) two frames, guard 3, ifg 4
    guard_len = 16'd3; ifg_len = 16'd4; frame_count = 16'd2;
    pulse_start();
    check("s1_state_pre", 64'(state), 64'd1);
    check("s1_busy",      64'(busy), 64'd1);
    check("s1_enable",    64'(dac_stream_enable), 64'd1);
    wait_state("s1_idle", 3'd0, 400);
    tick();
    build_expect(3, 4, 2);
    compare_stream("s1");
    if (cap_l.size() >= 58) begin
      check("s1_last27", 64'(cap_l[26]), 64'd1);
      check("s1_last58", 64'(cap_l[57]), 64'd1);
    end
    check("s1_frames",   64'(frames_sent), 64'd2);
    check("s1_underrun", 64'(underrun_cnt), 64'd0);

    // 2) no gaps, single frame
    do_reset();
    guard_len = 16'd0; ifg_len = 16'd0; frame_count = 16'd1;
    pulse_start();
    wait_state("s2_idle", 3'd0, 200);
    tick();
    build_expect(0, 0, 1);
    compare_stream("s2");
    check("s2_frames", 64'(frames_sent), 64'd1);

    // 3a) continuous mode, stop mid-payload -> finish packet, no IFG
    do_reset();
    guard_len = 16'd3; ifg_len = 16'd4; frame_count = 16'd0;
    pulse_start();
    wait_state("s3a_payload", 3'd3, 100);
    repeat (4) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_state("s3a_idle", 3'd0, 100);
    repeat (3) tick();
    build_expect(3, 4, 1);
    compare_stream("s3a");
    check("s3a_frames", 64'(frames_sent), 64'd1);

    // 3b) stop during GUARD -> IDLE next cycle
    do_reset();
    guard_len = 16'd3; ifg_len = 16'd4; frame_count = 16'd0;
    pulse_start();
    wait_state("s3b_guard", 3'd2, 100);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("s3b_state", 64'(state), 64'd0);
    check("s3b_busy",  64'(busy), 64'd0);
    tick();
    check("s3b_beats", 64'(cap_d.size()), 64'(PRE_LEN + 1));
    // start and stop together in IDLE: stay idle
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("s3b_startstop", 64'(state), 64'd0);

    // 4) payload starvation for 5 cycles
    do_reset();
    guard_len = 16'd3; ifg_len = 16'd4; frame_count = 16'd1;
    pulse_start();
    wait_state("s4_payload", 3'd3, 100);
    repeat (3) tick();
    s0_stall = 1'b1;
    repeat (5) tick();
    s0_stall = 1'b0;
    wait_state("s4_idle", 3'd0, 100);
    tick();
    check("s4_underrun", 64'(underrun_cnt), 64'd5);
    build_expect(3, 4, 1);
    compare_stream("s4");

    // 5) M_TREADY toggling, guard 3
    do_reset();
    guard_len = 16'd3; ifg_len = 16'd0; frame_count = 16'd1;
    toggle_rdy = 1'b1;
    pulse_start();
    wait_state("s5_idle", 3'd0, 400);
    toggle_rdy = 1'b0;
    tick();
    build_expect(3, 0, 1);
    compare_stream("s5");
    check("s5_underrun", 64'(underrun_cnt), 64'd0);

    // 6) reset mid-payload
    do_reset();
    guard_len = 16'd3; ifg_len = 16'd4; frame_count = 16'd1;
    pulse_start();
    wait_state("s6_payload", 3'd3, 100);
    repeat (3) tick();
    ARESET = 1'b1;
    #1;
    check("s6_state",   64'(state), 64'd0);
    check("s6_busy",    64'(busy), 64'd0);
    check("s6_tvalid",  64'(m_if.TVALID), 64'd0);
    check("s6_tlast",   64'(m_if.TLAST), 64'd0);
    check("s6_tdata",   64'(m_if.TDATA), 64'(ZW));
    check("s6_s0ready", 64'(s0_if.TREADY), 64'd0);
    check("s6_frames",  64'(frames_sent), 64'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("s6_start_in_rst", 64'(state), 64'd0);
    tick();
    ARESET = 1'b0;
    repeat (3) tick();
    check("s6_stay_idle", 64'(state), 64'd0);
    pulse_start();
    wait_state("s6_idle", 3'd0, 200);
    tick();
    build_expect(3, 4, 1);
    compare_stream("s6");
    check("s6_frames_end", 64'(frames_sent), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
